// File: rtl/inport_rx_fifo.sv
// Receive stage behind the bridge input port: captures one token per valid pulse into a small FIFO.
// Define INPORT_RX_SYNC2_EN to pass `valid` through a 2-flop synchronizer before the capture FSM.
module inport_rx_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk_inputport,
  input  logic          reset,
  input  logic          valid,
  input  logic [DW-1:0] din,
  output logic          take,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          err_udf
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_WAITLO
  } state_e;

  state_e          state_q, state_d;
  logic            valid_s;
  logic            wr_en;
  logic            rd_ok;
  logic            take_q;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            dout_vld_q, dout_vld_d;
  logic            err_q, err_d;
  logic [DW-1:0]   mem_q [DEPTH];

`ifdef INPORT_RX_SYNC2_EN
  logic [1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_inputport or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[0], valid};
  end

  assign valid_s = sync_q[1];
`else
  assign valid_s = valid;
`endif

  // Status is decoded from the registered pointers, so it reflects the state before this edge.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  always_ff @(posedge clk_inputport or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (valid_s && !full) state_d = S_ACK;
      S_ACK:    state_d = S_WAITLO;
      S_WAITLO: if (!valid_s) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_en = 1'b0;
    if (state_q == S_IDLE && valid_s && !full) wr_en = 1'b1;
  end

  assign rd_ok = rd_en && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    err_d      = err_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      dout_d     = mem_q[rd_ptr_q[AW-1:0]];
      dout_vld_d = 1'b1;
    end else if (rd_en) begin
      err_d = 1'b1;
    end
  end

  // take is registered from the next state so the port sees a clean single-cycle pulse.
  always_ff @(posedge clk_inputport or negedge reset) begin
    if (!reset) begin
      take_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      take_q     <= (state_d == S_ACK);
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      err_q      <= err_d;
    end
  end

  // NOTE: storage is not reset; zeroed pointers already make old contents unreachable.
  always_ff @(posedge clk_inputport) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign take     = take_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign err_udf  = err_q;

endmodule

// File: tb/tb_inport_rx_fifo.sv
// Self-checking bench for inport_rx_fifo: directed scenarios plus a random phase,
// all checked every cycle against a queue-based reference model.
module tb_inport_rx_fifo;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef INPORT_RX_SYNC2_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic          clk_inputport = 1'b0;
  logic          reset = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rd_en = 1'b0;
  logic          take;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          err_udf;

  inport_rx_fifo #(.DW(DW), .AW(AW)) dut (
    .clk_inputport (clk_inputport),
    .reset         (reset),
    .valid         (valid),
    .din           (din),
    .take          (take),
    .rd_en         (rd_en),
    .dout          (dout),
    .dout_vld      (dout_vld),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .err_udf       (err_udf)
  );

  always #5 clk_inputport = ~clk_inputport;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO contents, last popped word, sticky underflow flag,
  // and the port-side view of the current token (edges seen high, already captured).
  logic [DW-1:0] q_m[$];
  logic [DW-1:0] dout_m;
  logic          err_m;
  int            hi_cnt;
  bit            written;
  bit            prev_v;
  bit            last_take;
  int            n_take;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q_m.delete();
    dout_m  = '0;
    err_m   = 1'b0;
    hi_cnt  = 0;
    written = 1'b0;
    prev_v  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_take"},     32'(take),     32'd0);
    check({pfx, "_dout"},     32'(dout),     32'd0);
    check({pfx, "_dout_vld"}, 32'(dout_vld), 32'd0);
    check({pfx, "_empty"},    32'(empty),    32'd1);
    check({pfx, "_full"},     32'(full),     32'd0);
    check({pfx, "_count"},    32'(count),    32'd0);
    check({pfx, "_err_udf"},  32'(err_udf),  32'd0);
  endtask

  // One clock cycle: drive inputs, predict, advance past the edge, compare everything.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    bit pop_ok;
    bit wr_ok;
    valid = v;
    din   = d;
    rd_en = r;
    if (v && !prev_v) begin
      hi_cnt  = 0;
      written = 1'b0;
    end
    pop_ok = r && (q_m.size() != 0);
    wr_ok  = v && !written && (hi_cnt >= SYNC_LAT) && (q_m.size() < DEPTH);
    @(posedge clk_inputport);
    #1;
    if (v) hi_cnt++;
    prev_v = v;
    if (pop_ok) dout_m = q_m.pop_front();
    else if (r) err_m = 1'b1;
    if (wr_ok) begin
      q_m.push_back(d);
      written = 1'b1;
      n_take++;
    end
    last_take = wr_ok;
    check("take",     32'(take),     32'(wr_ok));
    check("dout_vld", 32'(dout_vld), 32'(pop_ok));
    check("dout",     32'(dout),     32'(dout_m));
    check("count",    32'(count),    32'(q_m.size()));
    check("empty",    32'(empty),    32'(q_m.size() == 0));
    check("full",     32'(full),     32'(q_m.size() == DEPTH));
    check("err_udf",  32'(err_udf),  32'(err_m));
  endtask

  // Present one token, wait (bounded) for take, then drop valid and leave a quiet gap.
  task automatic send(input logic [DW-1:0] d);
    int lat = 0;
    do begin
      step(1'b1, d, 1'b0);
      lat++;
    end while (!last_take && lat < 30);
    check("take_latency", 32'(lat), 32'(SYNC_LAT + 1));
    repeat (4) step(1'b0, d, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk_inputport);
    reset = 1'b1;
    @(posedge clk_inputport);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit            v;
    logic [DW-1:0] d;
    logic          r;
    int            low;
    int            guard;

    model_clear();
    n_take = 0;

    // Reset values
    #12;
    check_idle_outputs("reset");
    release_reset();

    // Single token, then pop it back
    send(8'hA5);
    check("single_count", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    check("single_dout", 32'(dout), 32'hA5);
    check("single_empty", 32'(empty), 32'd1);

    // Level held high for 10 cycles captures once
    n_take = 0;
    repeat (10) step(1'b1, 8'h3C, 1'b0);
    check("held_one_take", 32'(n_take), 32'd1);
    check("held_count", 32'(count), 32'd1);
    repeat (4) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);

    // Fill, backpressure on 5th token, simultaneous pop on full FIFO
    for (int i = 1; i <= 4; i++) send(8'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    n_take = 0;
    repeat (6) step(1'b1, 8'h05, 1'b0);
    check("bp_no_take", 32'(n_take), 32'd0);
    step(1'b1, 8'h05, 1'b1);
    check("simul_pop_01", 32'(dout), 32'h01);
    check("simul_no_write", 32'(take), 32'd0);
    step(1'b1, 8'h05, 1'b0);
    check("late_write_take", 32'(take), 32'd1);
    check("late_write_count", 32'(count), 32'd4);
    repeat (4) step(1'b0, 8'h00, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check("drain_order", 32'(dout), 32'(i));
    end

    // Pointer wrap over three fill/drain rounds
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) send(8'($urandom));
      check("wrap_full", 32'(full), 32'd1);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
      check("wrap_empty", 32'(empty), 32'd1);
    end

    // Underflow: dout held, dout_vld low, sticky error
    d = dout;
    step(1'b0, 8'h00, 1'b1);
    check("udf_dout_held", 32'(dout), 32'(d));
    check("udf_err", 32'(err_udf), 32'd1);
    repeat (5) step(1'b0, 8'h00, 1'b0);
    check("udf_sticky", 32'(err_udf), 32'd1);

    // Random traffic against the model
    v   = 1'b0;
    d   = '0;
    low = 4;
    for (int n = 0; n < 400; n++) begin
      r = (($urandom % 100) < 40);
      if (v && written) begin
        v   = 1'b0;
        low = 0;
      end else if (!v && low >= 4 && ($urandom % 3) == 0) begin
        v = 1'b1;
        d = 8'($urandom);
      end
      step(v, d, r);
      if (!v) low++;
    end
    if (v) begin
      guard = 0;
      while (!written && guard < 20) begin
        step(1'b1, d, 1'b1);
        guard++;
      end
      repeat (4) step(1'b0, d, 1'b0);
    end

    // Reset asserted while in ACK with two words stored
    guard = 0;
    while (q_m.size() != 0 && guard < 10) begin
      step(1'b0, 8'h00, 1'b1);
      guard++;
    end
    send(8'h11);
    guard = 0;
    do begin
      step(1'b1, 8'h22, 1'b0);
      guard++;
    end while (!last_take && guard < 30);
    check("ack_take", 32'(take), 32'd1);
    check("ack_count", 32'(count), 32'd2);
    #2;
    reset = 1'b0;
    valid = 1'b0;
    rd_en = 1'b0;
    #1;
    check_idle_outputs("midrst");
    model_clear();
    release_reset();
    check_idle_outputs("postrst");

    // Recovery after reset
    send(8'h5A);
    step(1'b0, 8'h00, 1'b1);
    check("recover_dout", 32'(dout), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
